// File: rtl/dmem_mmio_pkg.sv
// Shared DMType codes, MMIO register offsets and access-size decode for the
// data-memory subsystem.
package dmem_mmio_pkg;

  localparam logic [2:0] DM_WORD              = 3'b000;
  localparam logic [2:0] DM_HALFWORD          = 3'b001;
  localparam logic [2:0] DM_HALFWORD_UNSIGNED = 3'b010;
  localparam logic [2:0] DM_BYTE              = 3'b011;
  localparam logic [2:0] DM_BYTE_UNSIGNED     = 3'b100;

  localparam logic [3:0] MMIO_TXDATA = 4'h0;
  localparam logic [3:0] MMIO_STATUS = 4'h4;
  localparam logic [3:0] MMIO_CYCLES = 4'h8;
  localparam logic [3:0] MMIO_CTRL   = 4'hC;

  typedef enum logic [1:0] {
    ACC_BYTE,
    ACC_HALF,
    ACC_WORD
  } acc_size_e;

  // Undefined DMType codes behave as full-word accesses.
  function automatic acc_size_e acc_size(input logic [2:0] dm_type);
    case (dm_type)
      DM_BYTE, DM_BYTE_UNSIGNED:         return ACC_BYTE;
      DM_HALFWORD, DM_HALFWORD_UNSIGNED: return ACC_HALF;
      default:                           return ACC_WORD;
    endcase
  endfunction

endpackage

// File: rtl/dmem_mmio_sync_fifo.sv
// Synchronous FIFO with registered storage; head is forced to zero while empty
// so the consumer never sees stale data.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/dmem_mmio.sv
// Data memory for the MEM stage: word RAM with byte/half lanes and load extension,
// plus an MMIO window holding a TX FIFO, status, cycle counter and sticky error flags.
module dmem_mmio
  import dmem_mmio_pkg::*;
#(
  parameter int          DM_WORDS   = 1024,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_w,
  input  logic [2:0]  DMType,
  input  logic [31:0] Addr,
  input  logic [31:0] WData,
  output logic [31:0] RData,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        err_irq
);

  localparam int AW = (DM_WORDS > 1) ? $clog2(DM_WORDS) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  function automatic logic [3:0] store_be(input acc_size_e sz, input logic [1:0] a);
    case (sz)
      ACC_BYTE: return 4'b0001 << a;
      ACC_HALF: return a[1] ? 4'b1100 : 4'b0011;
      default:  return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [2:0] t,
                                              input logic [1:0] a);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] r;
    b = w[8*a +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (t)
      DM_BYTE:              r = b;
      DM_BYTE_UNSIGNED:     r = {24'b0, b};
      DM_HALFWORD:          r = h;
      DM_HALFWORD_UNSIGNED: r = {16'b0, h};
      default:              r = w;
    endcase
    return r;
  endfunction

  logic [31:0]   ram [DM_WORDS];
  acc_size_e     sz;
  logic          misaligned;
  logic          in_ram;
  logic          in_mmio;
  logic [3:0]    reg_off;
  logic [AW-1:0] ram_idx;
  logic          ram_we;
  logic [3:0]    be;
  logic [31:0]   wlane;
  logic          mmio_wr;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          ctrl_clear;
  logic          mis_set;
  logic          ovf_set;
  logic          mis_flag;
  logic          ovf_flag;
  logic [31:0]   cycles;
  logic [31:0]   mmio_word;
  logic [31:0]   raw_word;

  assign sz         = acc_size(DMType);
  assign misaligned = ((sz == ACC_HALF) && Addr[0]) || ((sz == ACC_WORD) && (Addr[1:0] != 2'b00));
  assign in_ram     = ({2'b00, Addr[31:2]} < 32'(DM_WORDS));
  assign in_mmio    = (Addr[31:4] == MMIO_BASE[31:4]);
  assign reg_off    = {Addr[3:2], 2'b00};
  assign ram_idx    = Addr[AW+1:2];

  assign ram_we = mem_w && in_ram && !misaligned;
  assign be     = store_be(sz, Addr[1:0]);
  assign wlane  = (sz == ACC_BYTE) ? {4{WData[7:0]}} :
                  (sz == ACC_HALF) ? {2{WData[15:0]}} : WData;

  assign mmio_wr    = mem_w && in_mmio && !misaligned;
  assign fifo_push  = mmio_wr && (reg_off == MMIO_TXDATA);
  assign ctrl_clear = mmio_wr && (reg_off == MMIO_CTRL) && WData[0];
  assign fifo_pop   = tx_valid && tx_ready;
  assign ovf_set    = fifo_push && fifo_full && !fifo_pop;
  // Misaligned loads outside the mapped regions are not errors: the address may be stale.
  assign mis_set    = misaligned && (mem_w || in_ram || in_mmio);

  // Reset sits in the sensitivity list only so a store issued while reset is low is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (reset && ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) ram[ram_idx][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycles   <= '0;
      mis_flag <= 1'b0;
      ovf_flag <= 1'b0;
    end else begin
      cycles   <= cycles + 32'd1;
      mis_flag <= mis_set || (mis_flag && !ctrl_clear);
      ovf_flag <= ovf_set || (ovf_flag && !ctrl_clear);
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (WData[7:0]),
    .rdata (tx_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign tx_valid = !fifo_empty;
  assign err_irq  = mis_flag || ovf_flag;

  always_comb begin
    mmio_word = '0;
    case (reg_off)
      MMIO_STATUS: mmio_word = {22'b0, ovf_flag, mis_flag, fifo_full, fifo_empty, 6'(fifo_count)};
      MMIO_CYCLES: mmio_word = cycles;
      default:     mmio_word = '0;
    endcase
    raw_word = in_ram ? ram[ram_idx] : (in_mmio ? mmio_word : 32'b0);
    RData    = misaligned ? 32'b0 : load_extend(raw_word, DMType, Addr[1:0]);
  end

endmodule

// File: tb/tb_dmem_mmio.sv
// Randomised and directed bench for dmem_mmio against a byte-array / queue reference model.
module tb_dmem_mmio;
  import dmem_mmio_pkg::*;

  localparam logic [31:0] MB = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_w = 1'b0;
  logic [2:0]  DMType = DM_WORD;
  logic [31:0] Addr = '0;
  logic [31:0] WData = '0;
  logic [31:0] RData;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        err_irq;

  int checks = 0;
  int failures = 0;

  logic [7:0] mref [0:4095];
  logic [7:0] q [$];
  logic       mis_m = 1'b0;
  logic       ovf_m = 1'b0;

  dmem_mmio dut (
    .clk      (clk),
    .reset    (reset),
    .mem_w    (mem_w),
    .DMType   (DMType),
    .Addr     (Addr),
    .WData    (WData),
    .RData    (RData),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .err_irq  (err_irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic int size_of(input logic [2:0] t);
    if (t == DM_BYTE || t == DM_BYTE_UNSIGNED) return 1;
    if (t == DM_HALFWORD || t == DM_HALFWORD_UNSIGNED) return 2;
    return 4;
  endfunction

  function automatic bit is_mis(input logic [31:0] a, input logic [2:0] t);
    return (int'(a[1:0]) % size_of(t)) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] t);
    int n;
    logic [31:0] v;
    n = size_of(t);
    v = '0;
    if (is_mis(a, t) || a >= 32'd4096) return '0;
    for (int i = 0; i < n; i++) v = v | (32'(mref[a + i]) << (8 * i));
    if ((t == DM_BYTE && v[7]) || (t == DM_HALFWORD && v[15])) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  function automatic logic [31:0] status_m();
    return {22'b0, ovf_m, mis_m, q.size() == 8, q.size() == 0, 6'(q.size())};
  endfunction

  task automatic access(input logic w, input logic [31:0] a, input logic [2:0] t,
                        input logic [31:0] d, output logic [31:0] r);
    mem_w = w; Addr = a; DMType = t; WData = d;
    #1 r = RData;
    @(posedge clk);
    @(negedge clk);
    mem_w = 1'b0;
  endtask

  // Reference update for one access; tx_ready must be low when pushing through here.
  task automatic model_access(input logic w, input logic [31:0] a, input logic [2:0] t,
                              input logic [31:0] d);
    bit mapped;
    mapped = (a < 32'd4096) || (a[31:4] == MB[31:4]);
    if (is_mis(a, t)) begin
      if (w || mapped) mis_m = 1'b1;
    end else if (w && a < 32'd4096) begin
      for (int i = 0; i < size_of(t); i++) mref[a + i] = d[8*i +: 8];
    end else if (w && a[31:4] == MB[31:4] && a[3:2] == 2'd0) begin
      if (q.size() == 8) ovf_m = 1'b1;
      else q.push_back(d[7:0]);
    end else if (w && a[31:4] == MB[31:4] && a[3:2] == 2'd3 && d[0]) begin
      mis_m = 1'b0;
      ovf_m = 1'b0;
    end
  endtask

  task automatic st(input logic [31:0] a, input logic [2:0] t, input logic [31:0] d);
    logic [31:0] r;
    access(1'b1, a, t, d, r);
    model_access(1'b1, a, t, d);
  endtask

  task automatic ld(input logic [31:0] a, input logic [2:0] t, output logic [31:0] r);
    access(1'b0, a, t, 32'h0, r);
    model_access(1'b0, a, t, 32'h0);
  endtask

  task automatic test_reset;
    logic [31:0] r;
    reset = 1'b1;
    #2 reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL rst_tx_valid got=%b exp=0", tx_valid); end
    checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL rst_tx_data got=%h exp=00", tx_data); end
    checks++; if (err_irq !== 1'b0) begin failures++; $display("FAIL rst_err_irq got=%b exp=0", err_irq); end
    reset = 1'b1;
    ld(MB + 32'h8, DM_WORD, r);
    checks++; if (r !== 32'h0) begin failures++; $display("FAIL rst_cycles got=%h exp=0", r); end
    ld(MB + 32'h4, DM_WORD, r);
    checks++; if (r !== 32'h40) begin failures++; $display("FAIL rst_status got=%h exp=00000040", r); end
  endtask

  task automatic test_ram_lanes;
    logic [31:0] r;
    st(32'h10, DM_WORD, 32'h8000_00F1);
    ld(32'h10, DM_BYTE, r);
    checks++; if (r !== 32'hFFFF_FFF1) begin failures++; $display("FAIL lb got=%h exp=fffffff1", r); end
    ld(32'h10, DM_BYTE_UNSIGNED, r);
    checks++; if (r !== 32'h0000_00F1) begin failures++; $display("FAIL lbu got=%h exp=000000f1", r); end
    ld(32'h12, DM_HALFWORD, r);
    checks++; if (r !== 32'hFFFF_8000) begin failures++; $display("FAIL lh got=%h exp=ffff8000", r); end
    ld(32'h12, DM_HALFWORD_UNSIGNED, r);
    checks++; if (r !== 32'h0000_8000) begin failures++; $display("FAIL lhu got=%h exp=00008000", r); end
    st(32'h20, DM_WORD, 32'h0);
    st(32'h23, DM_BYTE, 32'h1234_56AB);
    ld(32'h20, DM_WORD, r);
    checks++; if (r !== 32'hAB00_0000) begin failures++; $display("FAIL sb_lane got=%h exp=ab000000", r); end
    st(32'h20, DM_HALFWORD, 32'hFFFF_1234);
    ld(32'h20, DM_WORD, r);
    checks++; if (r !== 32'hAB00_1234) begin failures++; $display("FAIL sh_lane got=%h exp=ab001234", r); end
  endtask

  task automatic test_misalign;
    logic [31:0] r;
    ld(32'h22, DM_WORD, r);
    checks++; if (r !== 32'h0) begin failures++; $display("FAIL mis_lw got=%h exp=0", r); end
    checks++; if (err_irq !== 1'b1) begin failures++; $display("FAIL mis_irq_ld got=%b exp=1", err_irq); end
    ld(MB + 32'h4, DM_WORD, r);
    checks++; if (r !== status_m() || r[8] !== 1'b1) begin failures++; $display("FAIL mis_status got=%h exp=%h", r, status_m()); end
    st(MB + 32'hC, DM_WORD, 32'h1);
    checks++; if (err_irq !== 1'b0) begin failures++; $display("FAIL ctrl_clear got=%b exp=0", err_irq); end
    st(32'h21, DM_HALFWORD, 32'h5555);
    ld(32'h20, DM_WORD, r);
    checks++; if (r !== 32'hAB00_1234) begin failures++; $display("FAIL mis_sh_kept got=%h exp=ab001234", r); end
    checks++; if (err_irq !== 1'b1) begin failures++; $display("FAIL mis_irq_st got=%b exp=1", err_irq); end
    st(MB + 32'hC, DM_WORD, 32'h1);
    st(32'h1000_0000, DM_WORD, 32'hCAFE_F00D);
    ld(32'h1000_0000, DM_WORD, r);
    checks++; if (r !== 32'h0) begin failures++; $display("FAIL unmapped got=%h exp=0", r); end
    ld(32'h1000_0003, DM_WORD, r);
    checks++; if (err_irq !== 1'b0) begin failures++; $display("FAIL unmapped_mis_ld got=%b exp=0", err_irq); end
  endtask

  task automatic test_random;
    logic [31:0] r, a, d, e;
    logic [2:0]  t;
    logic        w;
    for (int i = 0; i < 64; i++) st(32'h100 + 32'(4 * i), DM_WORD, $urandom);
    for (int i = 0; i < 300; i++) begin
      a = 32'h100 + $urandom_range(0, 255);
      t = 3'($urandom_range(0, 4));
      w = 1'($urandom_range(0, 1));
      d = $urandom;
      if (w) st(a, t, d);
      else begin
        e = ref_load(a, t);
        ld(a, t, r);
        checks++; if (r !== e) begin failures++; $display("FAIL rand_load a=%h t=%0d got=%h exp=%h", a, t, r, e); end
      end
      checks++; if (err_irq !== (mis_m | ovf_m)) begin failures++; $display("FAIL rand_irq a=%h got=%b exp=%b", a, err_irq, mis_m | ovf_m); end
    end
    st(MB + 32'hC, DM_WORD, 32'h1);
  endtask

  task automatic test_fifo_overflow;
    logic [31:0] r;
    tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) st(MB, DM_WORD, $urandom);
    ld(MB + 32'h4, DM_WORD, r);
    checks++; if (r !== 32'h288 || r !== status_m()) begin failures++; $display("FAIL ovf_status got=%h exp=00000288", r); end
    checks++; if (err_irq !== 1'b1) begin failures++; $display("FAIL ovf_irq got=%b exp=1", err_irq); end
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++; if (tx_valid !== 1'b1 || tx_data !== q[0]) begin failures++; $display("FAIL drain%0d got=%b/%h exp=1/%h", i, tx_valid, tx_data, q[0]); end
      void'(q.pop_front());
      @(posedge clk);
      @(negedge clk);
    end
    #1;
    checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL drain_empty got=%b exp=0", tx_valid); end
    tx_ready = 1'b0;
    st(MB + 32'hC, DM_WORD, 32'h1);
  endtask

  task automatic test_push_pop_full;
    logic [31:0] r;
    logic [7:0]  nb;
    for (int i = 0; i < 8; i++) st(MB, DM_WORD, 32'(8'h30 + i));
    nb = 8'($urandom_range(0, 255));
    tx_ready = 1'b1;
    void'(q.pop_front());
    q.push_back(nb);
    access(1'b1, MB, DM_WORD, {24'h0, nb}, r);
    tx_ready = 1'b0;
    ld(MB + 32'h4, DM_WORD, r);
    checks++; if (r !== 32'h088) begin failures++; $display("FAIL pp_status got=%h exp=00000088", r); end
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++; if (tx_valid !== 1'b1 || tx_data !== q[0]) begin failures++; $display("FAIL pp_drain%0d got=%b/%h exp=1/%h", i, tx_valid, tx_data, q[0]); end
      void'(q.pop_front());
      @(posedge clk);
      @(negedge clk);
    end
    tx_ready = 1'b0;
    #1;
    checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL pp_empty got=%b exp=0", tx_valid); end
  endtask

  task automatic test_cycles;
    logic [31:0] c0, c1;
    ld(MB + 32'h8, DM_WORD, c0);
    repeat (99) @(negedge clk);
    ld(MB + 32'h8, DM_WORD, c1);
    checks++; if (c1 - c0 !== 32'd100) begin failures++; $display("FAIL cycles_delta got=%0d exp=100", c1 - c0); end
  endtask

  task automatic test_reset_mid_drain;
    logic [31:0] r;
    for (int i = 0; i < 4; i++) st(MB, DM_WORD, 32'(8'hA0 + i));
    ld(32'h12, DM_WORD, r);
    tx_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    Addr = MB + 32'h8; DMType = DM_WORD;
    #1;
    checks++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin failures++; $display("FAIL rst_mid_tx got=%b/%h exp=0/00", tx_valid, tx_data); end
    checks++; if (RData !== 32'h0) begin failures++; $display("FAIL rst_mid_cycles got=%h exp=0", RData); end
    checks++; if (err_irq !== 1'b0) begin failures++; $display("FAIL rst_mid_irq got=%b exp=0", err_irq); end
    mem_w = 1'b1; Addr = 32'h10; WData = 32'hDEAD_BEEF;
    @(posedge clk);
    @(negedge clk);
    mem_w = 1'b0;
    reset = 1'b1;
    tx_ready = 1'b0;
    q.delete(); mis_m = 1'b0; ovf_m = 1'b0;
    ld(32'h10, DM_WORD, r);
    checks++; if (r !== 32'h8000_00F1) begin failures++; $display("FAIL ram_kept got=%h exp=800000f1", r); end
    ld(MB + 32'h4, DM_WORD, r);
    checks++; if (r !== 32'h40) begin failures++; $display("FAIL rst_mid_status got=%h exp=00000040", r); end
  endtask

  initial begin
    test_reset;
    test_ram_lanes;
    test_misalign;
    test_random;
    test_fifo_overflow;
    test_push_pop_full;
    test_cycles;
    test_reset_mid_drain;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
